cmd_stream_initiator: RTL

- Initiator and checker for the host-command byte protocol; it sits on the opposite end of command_processor.
- On start, emits one 8-byte command on a byte AXI-stream master.
- For opcode 0, consumes the 32-bit response stream (tdata/tkeep/tlast) and checks every beat against the defined countdown pattern.
- Used as an on-chip loopback self-test of the command path and as the stimulus source in system benches.

---
 rtl/cmd_proto_pkg.sv | 39 +++
 rtl/resp_beat_checker.sv | 37 +++
 rtl/cmd_stream_initiator.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/cmd_proto_pkg.sv
// Shared definitions for the host-command byte protocol: opcodes, framing sizes,
// and the golden helpers that derive expected response keep and lane data from
// the remaining payload count R.
package cmd_proto_pkg;

   localparam logic [7:0] OP_SEND_LEN = 8'h00;   // only opcode that produces a response
   localparam int         CMD_BYTES   = 8;       // command is always 8 bytes
   localparam int         BEAT_W      = 32;      // response beat width
   localparam int         BEAT_BYTES  = BEAT_W / 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_RECV,
      ST_FIN
   } state_t;

   // Expected byte enables for a beat given R bytes still outstanding.
   function automatic logic [3:0] keep_from_rem(input logic [31:0] rem);
      logic [3:0] k;
      if (rem >= 32'd4) begin
         k = 4'b1111;
      end else begin
         case (rem[1:0])
            2'd3:    k = 4'b0111;
            2'd2:    k = 4'b0011;
            2'd1:    k = 4'b0001;
            default: k = 4'b0000;
         endcase
      end
      return k;
   endfunction

   // Countdown pattern: lane k carries (R[7:0] - 1 - k) mod 256.
   function automatic logic [7:0] exp_lane(input logic [31:0] rem, input logic [1:0] lane);
      return rem[7:0] - 8'd1 - {6'd0, lane};
   endfunction

endpackage

// File: rtl/resp_beat_checker.sv
// Golden model for one response beat: expected keep/last/data from R plus mismatch flag.
// Latency: purely combinational.
// Backpressure: none; evaluates whatever beat is presented.
// Ports: rem (bytes outstanding), tdata/tkeep/tlast (observed beat),
//        exp_keep/exp_last/exp_data (golden beat), mismatch, keep_pop (popcount of tkeep).
module resp_beat_checker
   import cmd_proto_pkg::*;
(
   input  logic [31:0] rem,
   input  logic [31:0] tdata,
   input  logic [3:0]  tkeep,
   input  logic        tlast,
   output logic [3:0]  exp_keep,
   output logic        exp_last,
   output logic [31:0] exp_data,
   output logic        mismatch,
   output logic [2:0]  keep_pop
);

   logic [31:0] data_mask;

   always_comb begin
      exp_keep  = keep_from_rem(rem);
      exp_last  = (rem < 32'd4);
      exp_data  = '0;
      data_mask = '0;
      for (int k = 0; k < BEAT_BYTES; k++) begin
         exp_data[8*k +: 8]  = exp_lane(rem, 2'(k));
         data_mask[8*k +: 8] = {8{exp_keep[k]}};
      end
      // Lanes outside the expected keep are don't-care; keep and last must match exactly.
      mismatch = (((tdata ^ exp_data) & data_mask) != 32'd0) ||
                 (tkeep != exp_keep) || (tlast != exp_last);
      keep_pop = 3'(tkeep[0]) + 3'(tkeep[1]) + 3'(tkeep[2]) + 3'(tkeep[3]);
   end

endmodule

// File: rtl/cmd_stream_initiator.sv
// Sends one 8-byte host command per start, then checks the countdown response for opcode 0.
// Latency: SEND begins the cycle after start; done pulses one cycle after the last handshake/beat.
// Backpressure: o_tdata holds while o_tready is low; i_tready = ~rx_hold in RECV, watchdog aborts stalls.
// Ports: clk/rstn; start, cmd_opcode, cmd_length, rx_hold (control);
//        o_tvalid/o_tready/o_tdata (byte master); i_tvalid/i_tready/i_tdata/i_tkeep/i_tlast (response slave);
//        busy, done, pass, timeout, err_count, byte_count (status).
module cmd_stream_initiator
   import cmd_proto_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int ERR_W          = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [7:0]       cmd_opcode,
   input  logic [31:0]      cmd_length,
   input  logic             rx_hold,
   input  logic             o_tready,
   output logic             o_tvalid,
   output logic [7:0]       o_tdata,
   output logic             i_tready,
   input  logic             i_tvalid,
   input  logic [31:0]      i_tdata,
   input  logic [3:0]       i_tkeep,
   input  logic             i_tlast,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [ERR_W-1:0] err_count,
   output logic [31:0]      byte_count
);

   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   state_t            state, state_nx;
   logic [7:0]        opcode_q;
   logic [31:0]       length_q;
   logic [31:0]       rem_q;
   logic [2:0]        idx_q;
   logic [WD_W-1:0]   wd_q;
   logic [ERR_W-1:0]  err_q;
   logic [31:0]       bytes_q;
   logic              pass_q;
   logic              timeout_q;

   logic [7:0]        tx_byte;
   logic              beat_acc;
   logic              wd_expire;
   logic              pass_calc;

   logic [3:0]        exp_keep;
   logic              exp_last;
   logic [31:0]       exp_data;
   logic              beat_bad;
   logic [2:0]        keep_pop;

   resp_beat_checker u_chk (
      .rem      (rem_q),
      .tdata    (i_tdata),
      .tkeep    (i_tkeep),
      .tlast    (i_tlast),
      .exp_keep (exp_keep),
      .exp_last (exp_last),
      .exp_data (exp_data),
      .mismatch (beat_bad),
      .keep_pop (keep_pop)
   );

   // Golden keep/data are only needed for debug probing; the mismatch flag carries the verdict.
   logic unused_golden;
   assign unused_golden = ^{exp_keep, exp_data};

   always_comb begin
      case (idx_q)
         3'd0:    tx_byte = opcode_q;
         3'd4:    tx_byte = length_q[7:0];
         3'd5:    tx_byte = length_q[15:8];
         3'd6:    tx_byte = length_q[23:16];
         3'd7:    tx_byte = length_q[31:24];
         default: tx_byte = 8'h00;
      endcase
   end

   assign beat_acc  = (state == ST_RECV) & i_tvalid & ~rx_hold;
   // An accepted beat in the expiry cycle wins and reloads the watchdog.
   assign wd_expire = (state == ST_RECV) & ~beat_acc & (wd_q == WD_LAST);
   assign pass_calc = (err_q == '0) & ~timeout_q &
                      ((opcode_q != OP_SEND_LEN) | (bytes_q == length_q));

   always_comb begin
      state_nx = state;
      o_tvalid = 1'b0;
      o_tdata  = 8'h00;
      i_tready = 1'b0;
      done     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nx = ST_SEND;
         end
         ST_SEND: begin
            o_tvalid = 1'b1;
            o_tdata  = tx_byte;
            if (o_tready && idx_q == 3'd7)
               state_nx = (opcode_q == OP_SEND_LEN) ? ST_RECV : ST_FIN;
         end
         ST_RECV: begin
            i_tready = ~rx_hold;
            if ((beat_acc && i_tlast) || wd_expire) state_nx = ST_FIN;
         end
         ST_FIN: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   assign busy       = (state != ST_IDLE);
   // Present the verdict alongside done; afterwards the registered copy holds it.
   assign pass       = (state == ST_FIN) ? pass_calc : pass_q;
   assign timeout    = timeout_q;
   assign err_count  = err_q;
   assign byte_count = bytes_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         opcode_q  <= 8'h00;
         length_q  <= 32'd0;
         rem_q     <= 32'd0;
         idx_q     <= 3'd0;
         wd_q      <= '0;
         err_q     <= '0;
         bytes_q   <= 32'd0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  opcode_q  <= cmd_opcode;
                  length_q  <= cmd_length;
                  rem_q     <= cmd_length;
                  idx_q     <= 3'd0;
                  wd_q      <= '0;
                  err_q     <= '0;
                  bytes_q   <= 32'd0;
                  pass_q    <= 1'b0;
                  timeout_q <= 1'b0;
               end
            end
            ST_SEND: begin
               wd_q <= '0;
               if (o_tready) idx_q <= idx_q + 3'd1;
            end
            ST_RECV: begin
               if (beat_acc) begin
                  // Clamp at zero so a missing tlast keeps expecting empty last beats.
                  rem_q   <= exp_last ? 32'd0 : rem_q - 32'd4;
                  bytes_q <= bytes_q + 32'(keep_pop);
                  if (beat_bad && err_q != {ERR_W{1'b1}}) err_q <= err_q + ERR_W'(1);
                  wd_q    <= '0;
               end else if (wd_q == WD_LAST) begin
                  timeout_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            ST_FIN: begin
               pass_q <= pass_calc;
            end
            default: ;
         endcase
      end
   end

endmodule
